// File: rtl/key_detect_module.sv
// Pushbutton debouncer: two-flop synchronizer feeding a four-state FSM.
// The FSM produces a debounced level plus press, release and long-press strobes.
module key_detect_module #(
   parameter logic [21:0] T_DB       = 22'd999_999,
   parameter logic [6:0]  LONG_TICKS = 7'd50
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic Key_In,
   output logic Key_Level,
   output logic Press_Pulse,
   output logic Release_Pulse,
   output logic Long_Press
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic        s1, s2;
   logic [21:0] count, count_nxt;
   logic [6:0]  long_cnt, long_cnt_nxt, long_cnt_inc;
   logic        long_flag, long_flag_nxt;
   logic        level_nxt, press_nxt, release_nxt, long_nxt;

   assign long_cnt_inc = long_cnt + 7'd1;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state         <= IDLE;
         s1            <= 1'b1;
         s2            <= 1'b1;
         count         <= '0;
         long_cnt      <= '0;
         long_flag     <= 1'b0;
         Key_Level     <= 1'b0;
         Press_Pulse   <= 1'b0;
         Release_Pulse <= 1'b0;
         Long_Press    <= 1'b0;
      end else begin
         state         <= state_nxt;
         s1            <= Key_In;
         s2            <= s1;
         count         <= count_nxt;
         long_cnt      <= long_cnt_nxt;
         long_flag     <= long_flag_nxt;
         Key_Level     <= level_nxt;
         Press_Pulse   <= press_nxt;
         Release_Pulse <= release_nxt;
         Long_Press    <= long_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      long_cnt_nxt  = long_cnt;
      long_flag_nxt = long_flag;
      level_nxt     = Key_Level;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      long_nxt      = 1'b0;
      case (state)
         IDLE: begin
            count_nxt = '0;
            if (!s2) state_nxt = PRESS_DB;
         end
         PRESS_DB: begin
            if (s2) begin
               state_nxt = IDLE;
               count_nxt = '0;
            end else if (count == T_DB) begin
               state_nxt     = HELD;
               count_nxt     = '0;
               long_cnt_nxt  = '0;
               long_flag_nxt = 1'b0;
               level_nxt     = 1'b1;
               press_nxt     = 1'b1;
            end else begin
               count_nxt = count + 22'd1;
            end
         end
         HELD: begin
            // A release seen on the wrap edge wins, so that wrap is not counted.
            if (s2) begin
               state_nxt = RELEASE_DB;
               count_nxt = '0;
            end else if (count == T_DB) begin
               count_nxt = '0;
               if (long_cnt != LONG_TICKS) begin
                  long_cnt_nxt = long_cnt_inc;
                  if (long_cnt_inc == LONG_TICKS && !long_flag) begin
                     long_nxt      = 1'b1;
                     long_flag_nxt = 1'b1;
                  end
               end
            end else begin
               count_nxt = count + 22'd1;
            end
         end
         RELEASE_DB: begin
            if (!s2) begin
               state_nxt = HELD;
               count_nxt = '0;
            end else if (count == T_DB) begin
               state_nxt     = IDLE;
               count_nxt     = '0;
               long_flag_nxt = 1'b0;
               level_nxt     = 1'b0;
               release_nxt   = 1'b1;
            end else begin
               count_nxt = count + 22'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
         end
      endcase
   end

endmodule

// File: doc/key_detect_module.md
Name: key_detect_module

Overview:
- Debounces one active-low pushbutton input and reports its state and its edges.
- Input-side counterpart of the LED flash output block. It runs on the same 50 MHz system clock and uses the same style of period-counter timing.
- Outputs are a debounced level, one-cycle press and release strobes, and a one-cycle long-press strobe. LED and control logic consume these outputs.

Parameters:
- T_DB, 22'd999_999, debounce window minus one in clocks (50 MHz × 20 ms − 1).
- LONG_TICKS, 7'd50, number of completed debounce windows while held before the long-press strobe (50 × 20 ms = 1 s).

Ports:
- CLK  input  1  system clock, 50 MHz, rising edge.
- RSTn  input  1  synchronous, active-low reset.
- Key_In  input  1  raw asynchronous pushbutton; 0 = pressed.
- Key_Level  output  1  debounced state; 1 = pressed.
- Press_Pulse  output  1  one-cycle strobe on a confirmed press.
- Release_Pulse  output  1  one-cycle strobe on a confirmed release.
- Long_Press  output  1  one-cycle strobe, at most once per press.

Behaviour:
- Clock and reset: single clock domain, CLK only. Reset is synchronous, active-low, sampled on the CLK rising edge.
- Reset values: state IDLE; both synchronizer flops 1; Count 0; LongCnt 0; Long_Flag 0; Key_Level 0; Press_Pulse 0; Release_Pulse 0; Long_Press 0.
- Reset mid-operation: aborts any state, with no strobe emitted on that cycle.
- Synchronizer: two flops, Key_In → s1 → s2. The state machine acts on s2 only.
- Counters:
  - Count is 22 bits and only ever counts 0..T_DB, so it never wraps past T_DB.
  - LongCnt is 7 bits and saturates at LONG_TICKS.
- All outputs are registered. Press_Pulse, Release_Pulse and Long_Press are never high for two consecutive cycles.
- State IDLE:
  - Count = 0.
  - s2 = 0 → PRESS_DB.
- State PRESS_DB:
  - Count increments each cycle.
  - s2 = 1 → IDLE, Count cleared, no strobe (bounce rejected).
  - Count == T_DB with s2 = 0 → HELD. On that edge: Key_Level←1, Press_Pulse←1, Count←0, LongCnt←0, Long_Flag←0.
- State HELD:
  - Count runs 0..T_DB and returns to 0.
  - On each return to 0, LongCnt increments (saturating).
  - On the edge LongCnt becomes LONG_TICKS with Long_Flag = 0: Long_Press←1, Long_Flag←1.
  - s2 = 1 → RELEASE_DB with Count←0. This takes priority over a simultaneous wrap, so LongCnt does not increment on that edge.
- State RELEASE_DB:
  - Count increments each cycle.
  - s2 = 0 → HELD with Count←0. LongCnt and Long_Flag are kept; there is no repeat Press_Pulse.
  - Count == T_DB with s2 = 1 → IDLE. On that edge: Key_Level←0, Release_Pulse←1, Long_Flag←0.
- Latency:
  - Press_Pulse rises T_DB+3 edges after the first edge that samples a stable Key_In = 0 (2 synchronizer edges + 1 IDLE→PRESS_DB edge + T_DB counting).
  - Release_Pulse rises T_DB+3 edges after the first edge that samples a stable Key_In = 1.
  - Long_Press rises LONG_TICKS·(T_DB+1) cycles after Press_Pulse, if the key stays held.
- Key held low through reset deassertion: the synchronizer reloads 0 within 2 cycles, then a normal press is reported with the standard latency.

Test Plan:
- Clean press with T_DB=9, LONG_TICKS=3:
  - Stimulus: Key_In driven low at sample edge 0 and held low.
  - Required response: Press_Pulse high only at edge 12; Key_Level 0 before edge 12 and 1 from edge 12.
- Bounce rejection (same parameters):
  - Stimulus: Key_In low 6 cycles, high 2, low 6, high 2, repeated for 100 cycles.
  - Required response: no strobes; Key_Level stays 0; state returns to IDLE after every high glitch.
- Long press (same parameters):
  - Stimulus: key held low for 50 cycles after Press_Pulse.
  - Required response: Long_Press high exactly once, 30 cycles after Press_Pulse; no further Long_Press.
- Release (same parameters):
  - Stimulus: Key_In released at edge E after a confirmed press.
  - Required response: Release_Pulse high only at E+12; Key_Level 0 from E+12.
  - Stimulus: a 3-cycle high glitch while held.
  - Required response: no Release_Pulse and no second Press_Pulse.
- Reset mid-debounce:
  - Stimulus: RSTn low for 1 cycle while in PRESS_DB with Count=5.
  - Required response: all outputs 0 the next cycle. With Key_In still low, Press_Pulse appears 12 edges after RSTn returns high.
- Default parameters, 50 MHz:
  - Stimulus: a stable 25 ms press.
  - Required response: Press_Pulse at 1,000,002 cycles.
  - Stimulus: a 1.5 s hold.
  - Required response: Long_Press exactly once, 50,000,000 cycles after Press_Pulse.
